mux_sequencer: RTL and testbench

MUX_SEQUENCER -- requirements
Module: mux_sequencer

---
 rtl/mux_sequencer.sv | 144 ++++++++++++++
 tb/tb_mux_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sequencer.sv
// rtl/mux_sequencer.sv - transmit framing sequencer: COM/STP/data/END framing with periodic SKP insertion
module mux_sequencer #(
  parameter int SKP_INTERVAL = 64
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       pkt_req,
  input  logic [7:0] pkt_len,
  input  logic       fifo_empty,
  output logic       pkt_ack,
  output logic       rd_en,
  output logic [1:0] control,
  output logic [7:0] start_end,
  output logic [7:0] ordered_set,
  output logic [7:0] logical_COM,
  output logic       busy,
  output logic       err_underrun
);

  localparam logic [1:0] CTL_DATA = 2'b00;
  localparam logic [1:0] CTL_SE   = 2'b01;
  localparam logic [1:0] CTL_OS   = 2'b10;
  localparam logic [1:0] CTL_COM  = 2'b11;
  localparam logic [7:0] SYM_STP  = 8'hFB;
  localparam logic [7:0] SYM_END  = 8'hFD;
  localparam logic [7:0] SYM_EDB  = 8'hFE;
  localparam logic [7:0] SYM_IDL  = 8'h7C;
  localparam logic [7:0] SYM_SKP  = 8'h1C;
  localparam logic [9:0] INTERVAL_LAST = 10'(SKP_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COM, S_STP, S_DATA, S_END, S_SKP_COM, S_SKP
  } state_t;

  state_t     state, state_next;
  logic [7:0] byte_cnt, byte_cnt_next;
  logic [1:0] skp_cnt, skp_cnt_next;
  logic [9:0] interval_cnt;
  logic       skp_pending, pending_clr, interval_hit;
  logic       edb, edb_next, ack_next;
  logic [1:0] control_next;
  logic [7:0] start_end_next, ordered_set_next;

  assign logical_COM  = 8'hBC;
  assign interval_hit = (interval_cnt == INTERVAL_LAST);

  // The FWFT flag must gate the pop in the same cycle, so these two follow the input directly.
  assign rd_en        = (state == S_DATA) && !fifo_empty;
  assign err_underrun = (state == S_DATA) && fifo_empty;

  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    skp_cnt_next  = skp_cnt;
    edb_next      = edb;
    ack_next      = 1'b0;
    pending_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (skp_pending) begin
          state_next  = S_SKP_COM;
          pending_clr = 1'b1;
        end else if (pkt_req) begin
          state_next    = S_COM;
          byte_cnt_next = pkt_len;
          ack_next      = 1'b1;
          edb_next      = 1'b0;
        end
      end
      S_COM:   state_next = S_STP;
      S_STP:   state_next = (byte_cnt == 8'd0) ? S_END : S_DATA;
      S_DATA: begin
        if (fifo_empty) begin
          state_next    = S_END;
          edb_next      = 1'b1;
          byte_cnt_next = 8'd0;
        end else begin
          byte_cnt_next = byte_cnt - 8'd1;
          if (byte_cnt == 8'd1) state_next = S_END;
        end
      end
      S_END:   state_next = S_IDLE;
      S_SKP_COM: begin
        state_next   = S_SKP;
        skp_cnt_next = 2'd0;
      end
      S_SKP: begin
        if (skp_cnt == 2'd2) state_next = S_IDLE;
        else skp_cnt_next = skp_cnt + 2'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    control_next     = CTL_OS;
    start_end_next   = 8'h00;
    ordered_set_next = SYM_IDL;
    case (state_next)
      S_COM, S_SKP_COM: control_next = CTL_COM;
      S_STP: begin
        control_next   = CTL_SE;
        start_end_next = SYM_STP;
      end
      S_DATA: control_next = CTL_DATA;
      S_END: begin
        control_next   = CTL_SE;
        start_end_next = edb_next ? SYM_EDB : SYM_END;
      end
      S_SKP: ordered_set_next = SYM_SKP;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state        <= S_IDLE;
      byte_cnt     <= 8'd0;
      skp_cnt      <= 2'd0;
      interval_cnt <= 10'd0;
      skp_pending  <= 1'b0;
      edb          <= 1'b0;
      pkt_ack      <= 1'b0;
      control      <= CTL_OS;
      start_end    <= 8'h00;
      ordered_set  <= SYM_IDL;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      byte_cnt     <= byte_cnt_next;
      skp_cnt      <= skp_cnt_next;
      interval_cnt <= interval_hit ? 10'd0 : interval_cnt + 10'd1;
      skp_pending  <= interval_hit | (skp_pending & ~pending_clr);
      edb          <= edb_next;
      pkt_ack      <= ack_next;
      control      <= control_next;
      start_end    <= start_end_next;
      ordered_set  <= ordered_set_next;
      busy         <= (state_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_mux_sequencer.sv
// tb/tb_mux_sequencer.sv - scoreboard bench for mux_sequencer with an 8-cycle SKP interval
module tb_mux_sequencer;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       pkt_req = 1'b0;
  logic [7:0] pkt_len = 8'd0;
  logic       fifo_empty = 1'b0;
  logic       pkt_ack, rd_en, busy, err_underrun;
  logic [1:0] control;
  logic [7:0] start_end, ordered_set, logical_COM;

  typedef struct packed {
    logic [1:0] control;
    logic [7:0] start_end;
    logic [7:0] ordered_set;
    logic [7:0] logical_com;
    logic       rd_en;
    logic       pkt_ack;
    logic       err;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];
  obs_t msk_q[$];
  obs_t ob, ev, em, rst_v;
  int   n_checks = 0;
  int   n_fail = 0;

  mux_sequencer #(.SKP_INTERVAL(8)) dut (
    .clk(clk), .reset_L(reset_L), .pkt_req(pkt_req), .pkt_len(pkt_len),
    .fifo_empty(fifo_empty), .pkt_ack(pkt_ack), .rd_en(rd_en), .control(control),
    .start_end(start_end), .ordered_set(ordered_set), .logical_COM(logical_COM),
    .busy(busy), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t s;
    s.control     = control;
    s.start_end   = start_end;
    s.ordered_set = ordered_set;
    s.logical_com = logical_COM;
    s.rd_en       = rd_en;
    s.pkt_ack     = pkt_ack;
    s.err         = err_underrun;
    s.busy        = busy;
    return s;
  endfunction

  // One character per cycle: I idle, K SKP COM, P SKP, C COM, S STP, D data byte,
  // U underrun cycle, E END(FD), F END(FE).
  task automatic push_seq(input string s);
    obs_t v, m;
    for (int i = 0; i < s.len(); i++) begin
      v = '0;
      m = '1;
      m.start_end = '0;
      m.ordered_set = '0;
      v.logical_com = 8'hBC;
      case (s[i])
        "I": begin v.control = 2'b10; v.ordered_set = 8'h7C; m.ordered_set = '1; end
        "K": begin v.control = 2'b11; v.busy = 1'b1; end
        "P": begin v.control = 2'b10; v.ordered_set = 8'h1C; m.ordered_set = '1; v.busy = 1'b1; end
        "C": begin v.control = 2'b11; v.pkt_ack = 1'b1; v.busy = 1'b1; end
        "S": begin v.control = 2'b01; v.start_end = 8'hFB; m.start_end = '1; v.busy = 1'b1; end
        "D": begin v.control = 2'b00; v.rd_en = 1'b1; v.busy = 1'b1; end
        "U": begin v.control = 2'b00; v.err = 1'b1; v.busy = 1'b1; end
        "E": begin v.control = 2'b01; v.start_end = 8'hFD; m.start_end = '1; v.busy = 1'b1; end
        "F": begin v.control = 2'b01; v.start_end = 8'hFE; m.start_end = '1; v.busy = 1'b1; end
        default: ;
      endcase
      exp_q.push_back(v);
      msk_q.push_back(m);
    end
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    pkt_req = 1'b0;
    pkt_len = 8'd0;
    fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    @(posedge clk);
    #2;
    ob = sample();
    n_checks++;
    if (ob !== rst_v) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", ob, rst_v);
    end
  endtask

  task automatic test_idle_skp();
    apply_reset();
    push_seq({"IIIIIIII", "KPPPIIII", "KPPPIIII", "KPPPIIII", "KPPP"});
    for (int cyc = 1; exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      @(negedge clk);
      ev = exp_q.pop_front(); em = msk_q.pop_front(); ob = sample();
      n_checks++;
      if (((ob ^ ev) & em) !== '0) begin
        n_fail++;
        $display("FAIL idle_skp cyc %0d: got %h expected %h mask %h", cyc, ob, ev, em);
      end
    end
  endtask

  task automatic test_single_packet();
    apply_reset();
    pkt_req = 1'b1; pkt_len = 8'd3;
    push_seq("CSDDDEIIKPPP");
    for (int cyc = 1; exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) pkt_req = 1'b0;
      @(negedge clk);
      ev = exp_q.pop_front(); em = msk_q.pop_front(); ob = sample();
      n_checks++;
      if (((ob ^ ev) & em) !== '0) begin
        n_fail++;
        $display("FAIL packet_len3 cyc %0d: got %h expected %h mask %h", cyc, ob, ev, em);
      end
    end
  endtask

  task automatic test_zero_length();
    apply_reset();
    pkt_req = 1'b1; pkt_len = 8'd0;
    push_seq("CSEIIIIIK");
    for (int cyc = 1; exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) pkt_req = 1'b0;
      @(negedge clk);
      ev = exp_q.pop_front(); em = msk_q.pop_front(); ob = sample();
      n_checks++;
      if (((ob ^ ev) & em) !== '0) begin
        n_fail++;
        $display("FAIL packet_len0 cyc %0d: got %h expected %h mask %h", cyc, ob, ev, em);
      end
    end
  endtask

  task automatic test_skp_priority();
    apply_reset();
    push_seq("IIIIIIIIKPPPICSDEIK");
    for (int cyc = 1; exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 8) begin pkt_req = 1'b1; pkt_len = 8'd1; end
      if (cyc == 14) pkt_req = 1'b0;
      @(negedge clk);
      ev = exp_q.pop_front(); em = msk_q.pop_front(); ob = sample();
      n_checks++;
      if (((ob ^ ev) & em) !== '0) begin
        n_fail++;
        $display("FAIL skp_priority cyc %0d: got %h expected %h mask %h", cyc, ob, ev, em);
      end
    end
  endtask

  task automatic test_underrun();
    apply_reset();
    pkt_req = 1'b1; pkt_len = 8'd5;
    push_seq("CSDDUFIIK");
    for (int cyc = 1; exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) pkt_req = 1'b0;
      if (cyc == 5) fifo_empty = 1'b1;
      if (cyc == 7) fifo_empty = 1'b0;
      @(negedge clk);
      ev = exp_q.pop_front(); em = msk_q.pop_front(); ob = sample();
      n_checks++;
      if (((ob ^ ev) & em) !== '0) begin
        n_fail++;
        $display("FAIL underrun cyc %0d: got %h expected %h mask %h", cyc, ob, ev, em);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    pkt_req = 1'b1; pkt_len = 8'd1;
    push_seq({"CSDEI", "CSDEI", "KPPPI", "CSDEI", "K"});
    for (int cyc = 1; exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 20) pkt_req = 1'b0;
      @(negedge clk);
      ev = exp_q.pop_front(); em = msk_q.pop_front(); ob = sample();
      n_checks++;
      if (((ob ^ ev) & em) !== '0) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h mask %h", cyc, ob, ev, em);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    pkt_req = 1'b1; pkt_len = 8'd5;
    push_seq("CSD");
    for (int cyc = 1; exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) pkt_req = 1'b0;
      @(negedge clk);
      ev = exp_q.pop_front(); em = msk_q.pop_front(); ob = sample();
      n_checks++;
      if (((ob ^ ev) & em) !== '0) begin
        n_fail++;
        $display("FAIL pre_reset cyc %0d: got %h expected %h mask %h", cyc, ob, ev, em);
      end
    end
    #2 reset_L = 1'b0;
    #1;
    ob = sample();
    n_checks++;
    if (ob !== rst_v) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", ob, rst_v);
    end
    apply_reset();
    pkt_req = 1'b1; pkt_len = 8'd2;
    push_seq("CSDDEIIIK");
    for (int cyc = 1; exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) pkt_req = 1'b0;
      @(negedge clk);
      ev = exp_q.pop_front(); em = msk_q.pop_front(); ob = sample();
      n_checks++;
      if (((ob ^ ev) & em) !== '0) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d: got %h expected %h mask %h", cyc, ob, ev, em);
      end
    end
  endtask

  initial begin
    rst_v = '0;
    rst_v.control = 2'b10;
    rst_v.ordered_set = 8'h7C;
    rst_v.logical_com = 8'hBC;
    test_reset();
    test_idle_skp();
    test_single_packet();
    test_zero_length();
    test_skp_priority();
    test_underrun();
    test_back_to_back();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
